stopwatch_lap: RTL and testbench

Parametrised successor to the single-channel free-running stopwatch. It keeps a centisecond/second/minute/hour time counter from a tick enable derived in the system clock domain; there is no gated or divided clock. It adds lap capture into a LAP_DEPTH-entry FIFO with a valid/ready read port, a synchronous clear, a wrap indication, and correct modulo rollover at every digit. It sits between the board clock and the display/UART formatting logic.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_lap_if.sv | 24 ++
 rtl/stopwatch_lap_fifo.sv | 73 +++++++
 rtl/stopwatch_lap.sv | 201 ++++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared time record, digit limits and divider sizing for the lap stopwatch.
package stopwatch_pkg;

    typedef struct packed {
        logic [6:0] hour;
        logic [6:0] minute;
        logic [6:0] second;
        logic [7:0] m_sec;
    } time_t;

    localparam logic [7:0] MSEC_MAX = 8'd99;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;

    // Bits needed to count 0..CLK_HZ/TICK_HZ-1; never less than one.
    function automatic int unsigned div_width(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
        int unsigned ratio;
        ratio = clk_hz / tick_hz;
        return (ratio <= 1) ? 32'd1 : 32'($clog2(ratio));
    endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Lap read port: valid/ready handshake carrying the FIFO head entry and occupancy.
interface stopwatch_lap_if #(
    parameter int unsigned LAP_DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(LAP_DEPTH) + 1;

    logic             lap_valid;
    logic             lap_ready;
    logic [6:0]       lap_hour;
    logic [6:0]       lap_minute;
    logic [6:0]       lap_second;
    logic [7:0]       lap_m_sec;
    logic [CNT_W-1:0] lap_count;

    modport master (
        output lap_valid, lap_hour, lap_minute, lap_second, lap_m_sec, lap_count,
        input  lap_ready
    );

    modport slave (
        input  lap_valid, lap_hour, lap_minute, lap_second, lap_m_sec, lap_count,
        output lap_ready
    );
endinterface

// File: rtl/stopwatch_lap_fifo.sv
// First-word-fall-through FIFO of time_t; head is registered and holds its last
// value while the FIFO is empty.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  time_t            wdata,
    output time_t            rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    time_t            mem_q [DEPTH];
    time_t            head_q, head_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            head_d  = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (count_d != '0) begin
                head_d = (do_push && (wr_q == rd_d)) ? wdata : mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
            if (do_push) mem_q[wr_q] <= wdata;
        end
    end

    assign rdata = head_q;
    assign count = count_q;

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with tick divider, one-cycle carry chain, lap FIFO and sticky flags.
// Optional down-counting with load/done is enabled by STOPWATCH_COUNTDOWN_EN.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned MAX_HOURS = 24,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       clear,
    input  logic       lap,
    output logic [6:0] hour,
    output logic [6:0] minute,
    output logic [6:0] second,
    output logic [7:0] m_sec,
    output logic       lap_overflow,
    output logic       wrapped,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic       mode,
    input  logic       load,
    input  logic [6:0] load_hour,
    input  logic [6:0] load_minute,
    input  logic [6:0] load_second,
    input  logic [7:0] load_m_sec,
    output logic       done,
`endif
    stopwatch_lap_if.master lap_port
);

    localparam int unsigned    DIV_W    = div_width(CLK_HZ, TICK_HZ);
    localparam int unsigned    CNT_W    = $clog2(LAP_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ / TICK_HZ - 1);
    localparam logic [6:0]     HOUR_MAX = 7'(MAX_HOURS - 1);

    time_t            time_q, time_d, time_inc;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick, wrap_hit;
    logic             wrapped_q, wrapped_d, overflow_q, overflow_d;
    logic             fifo_full, fifo_empty;
    time_t            fifo_head;
    logic [CNT_W-1:0] fifo_count;

    assign tick = run && (div_q == DIV_MAX);

    always_comb begin
        time_inc = time_q;
        wrap_hit = 1'b0;
        if (time_q.m_sec != MSEC_MAX) begin
            time_inc.m_sec = time_q.m_sec + 8'd1;
        end else begin
            time_inc.m_sec = '0;
            if (time_q.second != SEC_MAX) begin
                time_inc.second = time_q.second + 7'd1;
            end else begin
                time_inc.second = '0;
                if (time_q.minute != MIN_MAX) begin
                    time_inc.minute = time_q.minute + 7'd1;
                end else begin
                    time_inc.minute = '0;
                    if (time_q.hour != HOUR_MAX) begin
                        time_inc.hour = time_q.hour + 7'd1;
                    end else begin
                        time_inc.hour = '0;
                        wrap_hit      = 1'b1;
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    time_t time_dec, time_load;
    logic  done_q, done_d;

    always_comb begin
        time_dec = time_q;
        if (time_q.m_sec != '0) begin
            time_dec.m_sec = time_q.m_sec - 8'd1;
        end else begin
            time_dec.m_sec = MSEC_MAX;
            if (time_q.second != '0) begin
                time_dec.second = time_q.second - 7'd1;
            end else begin
                time_dec.second = SEC_MAX;
                if (time_q.minute != '0) begin
                    time_dec.minute = time_q.minute - 7'd1;
                end else begin
                    time_dec.minute = MIN_MAX;
                    time_dec.hour   = (time_q.hour != '0) ? time_q.hour - 7'd1 : HOUR_MAX;
                end
            end
        end
    end

    always_comb begin
        time_load.hour   = (load_hour   > HOUR_MAX) ? HOUR_MAX : load_hour;
        time_load.minute = (load_minute > MIN_MAX)  ? MIN_MAX  : load_minute;
        time_load.second = (load_second > SEC_MAX)  ? SEC_MAX  : load_second;
        time_load.m_sec  = (load_m_sec  > MSEC_MAX) ? MSEC_MAX : load_m_sec;
    end
`endif

    always_comb begin
        time_d     = time_q;
        div_d      = div_q;
        wrapped_d  = wrapped_q;
        overflow_d = overflow_q;
`ifdef STOPWATCH_COUNTDOWN_EN
        done_d     = done_q;
`endif
        if (clear) begin
            time_d     = '0;
            div_d      = '0;
            wrapped_d  = 1'b0;
            overflow_d = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
            done_d     = 1'b0;
`endif
        end else begin
            if (run) div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            // Full FIFO drops the lap unless the consumer frees a slot this cycle.
            if (lap && fifo_full && !lap_port.lap_ready) overflow_d = 1'b1;
`ifdef STOPWATCH_COUNTDOWN_EN
            if (load) begin
                time_d = time_load;
                done_d = 1'b0;
            end else if (tick && !done_q) begin
                if (mode) begin
                    if (time_q == '0) done_d = 1'b1;
                    else              time_d = time_dec;
                end else begin
                    time_d = time_inc;
                    if (wrap_hit) wrapped_d = 1'b1;
                end
            end
`else
            if (tick) begin
                time_d = time_inc;
                if (wrap_hit) wrapped_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            time_q     <= '0;
            div_q      <= '0;
            wrapped_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
            done_q     <= 1'b0;
`endif
        end else begin
            time_q     <= time_d;
            div_q      <= div_d;
            wrapped_q  <= wrapped_d;
            overflow_q <= overflow_d;
`ifdef STOPWATCH_COUNTDOWN_EN
            done_q     <= done_d;
`endif
        end
    end

    lap_fifo #(
        .DEPTH(LAP_DEPTH)
    ) u_lap_fifo (
        .clk  (clock),
        .rst_n(reset_n),
        .flush(clear),
        .push (lap),
        .pop  (lap_port.lap_ready),
        .wdata(time_q),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign hour         = time_q.hour;
    assign minute       = time_q.minute;
    assign second       = time_q.second;
    assign m_sec        = time_q.m_sec;
    assign wrapped      = wrapped_q;
    assign lap_overflow = overflow_q;
`ifdef STOPWATCH_COUNTDOWN_EN
    assign done         = done_q;
`endif

    assign lap_port.lap_valid  = !fifo_empty;
    assign lap_port.lap_hour   = fifo_head.hour;
    assign lap_port.lap_minute = fifo_head.minute;
    assign lap_port.lap_second = fifo_head.second;
    assign lap_port.lap_m_sec  = fifo_head.m_sec;
    assign lap_port.lap_count  = fifo_count;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: directed table, hand sequences and a random run
// against a centisecond-count reference model.
module tb_stopwatch_lap;
    import stopwatch_pkg::*;

    localparam int unsigned CLK_HZ = 1000, TICK_HZ = 100, MAX_H = 2, DEPTH = 4;
    localparam int DIVN  = CLK_HZ / TICK_HZ;
    localparam int TOTAL = MAX_H * 360000;

    logic       clock, reset_n, run, clear, lap;
    logic [6:0] hour, minute, second;
    logic [7:0] m_sec;
    logic       lap_overflow, wrapped;
`ifdef STOPWATCH_COUNTDOWN_EN
    logic       mode = 1'b0, load = 1'b0, done;
    logic [6:0] load_hour = '0, load_minute = '0, load_second = '0;
    logic [7:0] load_m_sec = '0;
`endif

    stopwatch_lap_if #(.LAP_DEPTH(DEPTH)) lap_if ();

    stopwatch_lap #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_HOURS(MAX_H), .LAP_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .clear(clear), .lap(lap),
        .hour(hour), .minute(minute), .second(second), .m_sec(m_sec),
        .lap_overflow(lap_overflow), .wrapped(wrapped),
`ifdef STOPWATCH_COUNTDOWN_EN
        .mode(mode), .load(load), .load_hour(load_hour), .load_minute(load_minute),
        .load_second(load_second), .load_m_sec(load_m_sec), .done(done),
`endif
        .lap_port(lap_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0, n_pass = 0;

    // Reference model: elapsed time as a plain centisecond count.
    int m_cs, m_div, m_head;
    int m_q[$];
    bit m_ovf, m_wrp;

    function automatic void chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    endfunction

    function automatic void model_reset();
        m_cs = 0; m_div = 0; m_head = 0; m_ovf = 0; m_wrp = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge();
        bit tick_now, pop_now;
        int snap;
        pop_now = (m_q.size() > 0) && lap_if.lap_ready;
        if (clear) begin
            model_reset();
            return;
        end
        tick_now = run && (m_div == DIVN - 1);
        snap = m_cs;
        if (tick_now) begin
            m_cs = m_cs + 1;
            if (m_cs == TOTAL) begin m_cs = 0; m_wrp = 1; end
        end
        if (run) m_div = tick_now ? 0 : m_div + 1;
        if (lap && m_q.size() == DEPTH && !pop_now) m_ovf = 1;
        if (pop_now) void'(m_q.pop_front());
        if (lap && m_q.size() < DEPTH) m_q.push_back(snap);
        if (m_q.size() > 0) m_head = m_q[0];
    endfunction

    function automatic void check_all(input string tag);
        chk({tag, " hour"},   int'(hour),   m_cs / 360000);
        chk({tag, " minute"}, int'(minute), (m_cs / 6000) % 60);
        chk({tag, " second"}, int'(second), (m_cs / 100) % 60);
        chk({tag, " m_sec"},  int'(m_sec),  m_cs % 100);
        chk({tag, " lap_valid"}, int'(lap_if.lap_valid), int'(m_q.size() > 0));
        chk({tag, " lap_count"}, int'(lap_if.lap_count), m_q.size());
        chk({tag, " lap_hour"},   int'(lap_if.lap_hour),   m_head / 360000);
        chk({tag, " lap_minute"}, int'(lap_if.lap_minute), (m_head / 6000) % 60);
        chk({tag, " lap_second"}, int'(lap_if.lap_second), (m_head / 100) % 60);
        chk({tag, " lap_m_sec"},  int'(lap_if.lap_m_sec),  m_head % 100);
        chk({tag, " overflow"}, int'(lap_overflow), int'(m_ovf));
        chk({tag, " wrapped"},  int'(wrapped),      int'(m_wrp));
    endfunction

    function automatic void check_time(input string tag, input int h, input int mi,
                                       input int s, input int ms);
        chk({tag, " hour"}, int'(hour), h);
        chk({tag, " minute"}, int'(minute), mi);
        chk({tag, " second"}, int'(second), s);
        chk({tag, " m_sec"}, int'(m_sec), ms);
    endfunction

    task automatic cycle(input string tag = "cyc");
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0; clear = 1'b0; lap = 1'b0; lap_if.lap_ready = 1'b0;
        #3;
        model_reset();
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    typedef struct {
        bit run; bit lap; bit ready; int ncyc; int exp_cs; int exp_count; bit exp_ovf;
    } vec_t;
    vec_t vecs[10];
    int drain_a[4];
    int drain_b[4];
    time_t force_t;

    initial begin
        vecs[0] = '{1, 0, 0, 249,  24, 0, 0};
        vecs[1] = '{1, 1, 0,   1,  25, 1, 0};
        vecs[2] = '{1, 0, 0, 249,  49, 1, 0};
        vecs[3] = '{1, 1, 0,   1,  50, 2, 0};
        vecs[4] = '{1, 0, 0, 249,  74, 2, 0};
        vecs[5] = '{1, 1, 0,   1,  75, 3, 0};
        vecs[6] = '{1, 0, 0, 249,  99, 3, 0};
        vecs[7] = '{1, 1, 0,   1, 100, 4, 0};
        vecs[8] = '{1, 0, 0, 249, 124, 4, 0};
        vecs[9] = '{1, 1, 0,   1, 125, 4, 1};
        drain_a = '{24, 49, 74, 99};
        drain_b = '{1, 2, 3, 4};

        do_reset();

        // 1000 running clocks is exactly one second.
        run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cycle("run1s");
            chk("m_sec<=99", int'(m_sec <= 8'd99), 1);
        end
        check_time("one_second", 0, 0, 1, 0);

        // Laps into a depth-4 FIFO with no consumer; the fifth is dropped.
        do_reset();
        foreach (vecs[v]) begin
            run = vecs[v].run; lap = vecs[v].lap; lap_if.lap_ready = vecs[v].ready;
            repeat (vecs[v].ncyc) cycle("table");
            check_time("table_time", 0, 0, vecs[v].exp_cs / 100, vecs[v].exp_cs % 100);
            chk("table_count", int'(lap_if.lap_count), vecs[v].exp_count);
            chk("table_ovf", int'(lap_overflow), int'(vecs[v].exp_ovf));
        end
        lap = 1'b0; run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", int'(lap_if.lap_valid), 1);
            chk("drain_m_sec", int'(lap_if.lap_m_sec), drain_a[i]);
            lap_if.lap_ready = 1'b1;
            cycle("drain");
            lap_if.lap_ready = 1'b0;
        end
        chk("drained_valid", int'(lap_if.lap_valid), 0);
        chk("drained_count", int'(lap_if.lap_count), 0);
        chk("drained_hold", int'(lap_if.lap_m_sec), 99);
        chk("drained_ovf_sticky", int'(lap_overflow), 1);

        // Full FIFO with simultaneous push and pop.
        clear = 1'b1;
        cycle("clear");
        clear = 1'b0;
        chk("clr_ovf", int'(lap_overflow), 0);
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lap = 1'b0;
            repeat (9) cycle("fill");
            lap = 1'b1;
            cycle("fill");
        end
        lap = 1'b0;
        chk("full_count", int'(lap_if.lap_count), 4);
        chk("full_head", int'(lap_if.lap_m_sec), 0);
        lap = 1'b1; lap_if.lap_ready = 1'b1;
        cycle("pushpop");
        lap = 1'b0; lap_if.lap_ready = 1'b0; run = 1'b0;
        chk("pushpop_count", int'(lap_if.lap_count), 4);
        chk("pushpop_head", int'(lap_if.lap_m_sec), 1);
        chk("pushpop_ovf", int'(lap_overflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain2_m_sec", int'(lap_if.lap_m_sec), drain_b[i]);
            lap_if.lap_ready = 1'b1;
            cycle("drain2");
            lap_if.lap_ready = 1'b0;
        end

        // Pause at divider 6: partial period resumes.
        do_reset();
        run = 1'b1;
        repeat (16) cycle("pre_pause");
        run = 1'b0;
        repeat (37) cycle("paused");
        check_time("paused", 0, 0, 0, 1);
        run = 1'b1;
        repeat (3) cycle("resume");
        check_time("resume3", 0, 0, 0, 1);
        cycle("resume");
        check_time("resume4", 0, 0, 0, 2);

        // Clear beats tick and lap at 0:00:00:99.
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 999; i++) begin
            lap = (i >= 100 && i <= 104);
            cycle("pre_clear");
        end
        lap = 1'b0;
        check_time("pre_clear", 0, 0, 0, 99);
        chk("pre_clear_ovf", int'(lap_overflow), 1);
        clear = 1'b1; lap = 1'b1;
        cycle("clear_tick");
        clear = 1'b0; lap = 1'b0;
        check_time("clear_tick", 0, 0, 0, 0);
        chk("clear_count", int'(lap_if.lap_count), 0);
        chk("clear_valid", int'(lap_if.lap_valid), 0);
        chk("clear_ovf", int'(lap_overflow), 0);

        // Asynchronous reset while tick is high.
        for (int i = 0; i < 2 * DIVN && m_div != DIVN - 1; i++) cycle("to_tick");
        chk("at_tick_phase", m_div, DIVN - 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0, 0);
        chk("async_rst_valid", int'(lap_if.lap_valid), 0);
        model_reset();
        run = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_all("after_rst");

        // Wrap: preset to 1:59:59:98 with the counter paused.
        force_t.hour = 7'd1; force_t.minute = 7'd59;
        force_t.second = 7'd59; force_t.m_sec = 8'd98;
        force dut.time_q = force_t;
        @(posedge clock);
        #1;
        release dut.time_q;
        m_cs = TOTAL - 2;
        check_all("preset");
        run = 1'b1;
        repeat (10) cycle("wrap");
        check_time("max_time", 1, 59, 59, 99);
        chk("wrapped_before", int'(wrapped), 0);
        repeat (10) cycle("wrap");
        check_time("wrapped_time", 0, 0, 0, 0);
        chk("wrapped_after", int'(wrapped), 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            run   = ($urandom_range(0, 9) != 0);
            lap   = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 199) == 0);
            lap_if.lap_ready = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
